// File: rtl/add32_arb_pkg.sv
// Shared definitions for add32_arbiter.
// Contents: datapath width, sequencer FSM state type and saturation clamp constants.
package add32_arb_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] SAT_POS  = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] SAT_NEG  = 32'h8000_0000;
  localparam logic [DATA_W-1:0] SAT_UMAX = 32'hFFFF_FFFF;
  localparam logic [DATA_W-1:0] SAT_UMIN = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StHold
  } state_e;

endpackage

// File: rtl/add32.sv
// Add32: 32-bit carry-lookahead adder/subtractor with overflow detection.
// Ports:
//   a_i, b_i  operands
//   sub_i     1 = a - b, 0 = a + b
//   sign_i    1 = two's-complement overflow rule, 0 = unsigned carry/borrow rule
//   sum_o     wrapped 32-bit result
//   ovf_o     overflow flag
module add32
  import add32_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  input  logic              sign_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              ovf_o
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] gen;
  logic [DATA_W-1:0] prop;
  logic [DATA_W-1:0] cin;
  logic              cout;

  always_comb begin
    logic c;
    b_eff = b_i ^ {DATA_W{sub_i}};
    gen   = a_i & b_eff;
    prop  = a_i ^ b_eff;
    cin   = '0;
    c     = sub_i;
    // 4-bit lookahead groups; group carries ripple between groups.
    for (int grp = 0; grp < int'(DATA_W / 4); grp++) begin
      cin[4*grp]   = c;
      cin[4*grp+1] = gen[4*grp] | (prop[4*grp] & c);
      cin[4*grp+2] = gen[4*grp+1] | (prop[4*grp+1] & gen[4*grp])
                   | (prop[4*grp+1] & prop[4*grp] & c);
      cin[4*grp+3] = gen[4*grp+2] | (prop[4*grp+2] & gen[4*grp+1])
                   | (prop[4*grp+2] & prop[4*grp+1] & gen[4*grp])
                   | (prop[4*grp+2] & prop[4*grp+1] & prop[4*grp] & c);
      c            = gen[4*grp+3] | (prop[4*grp+3] & gen[4*grp+2])
                   | (prop[4*grp+3] & prop[4*grp+2] & gen[4*grp+1])
                   | (prop[4*grp+3] & prop[4*grp+2] & prop[4*grp+1] & gen[4*grp])
                   | (prop[4*grp+3] & prop[4*grp+2] & prop[4*grp+1] & prop[4*grp] & c);
    end
    cout  = c;
    sum_o = prop ^ cin;
    if (sign_i) begin
      ovf_o = cout ^ cin[DATA_W-1];
    end else if (sub_i) begin
      ovf_o = ~cout;  // no carry out of a + ~b + 1 means a < b
    end else begin
      ovf_o = cout;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant selection.
// Ports:
//   req_i  request vector
//   ptr_i  highest-priority requester index
//   en_i   grant enable; no grant when low
//   gnt_o  one-hot grant
//   idx_o  encoded index of the granted requester (0 when none)
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);

  always_comb begin
    logic           found;
    logic [IDW-1:0] cand;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr_i) + k) % NREQ);
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/add32_arbiter.sv
// add32_arbiter: shares one Add32 adder/subtractor among NREQ requesters.
// Round-robin grant in IDLE, operands registered, result computed in CALC,
// response held in HOLD until consumed.
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake (req_ready only in IDLE)
//   req_a, req_b          packed operands, requester i at [32*i+31:32*i]
//   req_sub, req_sign     per-requester operation select
//   rsp_valid/rsp_ready   response handshake
//   rsp_id, rsp_result, rsp_overflow  tagged response
// Build option: ADD32_ARB_SAT_EN clamps the result on overflow.
module add32_arbiter
  import add32_arb_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ-1:0]        req_sub,
  input  logic [NREQ-1:0]        req_sign,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [DATA_W-1:0]      rsp_result,
  output logic                   rsp_overflow
);

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [DATA_W-1:0] a_q, b_q;
  logic              sub_q, sign_q;
  logic [IDW-1:0]    id_q;
  logic [DATA_W-1:0] res_q, res_d;
  logic              ovf_q;
  logic [IDW-1:0]    rsp_id_q;

  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_idx;
  logic              accept;
  logic [DATA_W-1:0] sum;
  logic              ovf;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .en_i (state_q == StIdle),
    .gnt_o(gnt),
    .idx_o(gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;

  add32 u_add32 (
    .a_i   (a_q),
    .b_i   (b_q),
    .sub_i (sub_q),
    .sign_i(sign_q),
    .sum_o (sum),
    .ovf_o (ovf)
  );

  always_comb begin
    res_d = sum;
`ifdef ADD32_ARB_SAT_EN
    if (ovf) begin
      if (sign_q) begin
        // Signed overflow: the true result carries the sign of a.
        res_d = a_q[DATA_W-1] ? SAT_NEG : SAT_POS;
      end else begin
        res_d = sub_q ? SAT_UMIN : SAT_UMAX;
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StCalc;
          ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      StCalc: state_d = StHold;
      StHold: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      sign_q <= 1'b0;
      id_q   <= '0;
    end else if (accept) begin
      a_q    <= req_a[DATA_W*gnt_idx +: DATA_W];
      b_q    <= req_b[DATA_W*gnt_idx +: DATA_W];
      sub_q  <= req_sub[gnt_idx];
      sign_q <= req_sign[gnt_idx];
      id_q   <= gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q    <= '0;
      ovf_q    <= 1'b0;
      rsp_id_q <= '0;
    end else if (state_q == StCalc) begin
      res_q    <= res_d;
      ovf_q    <= ovf;
      rsp_id_q <= id_q;
    end
  end

  assign rsp_valid    = (state_q == StHold);
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = res_q;
  assign rsp_overflow = ovf_q;

endmodule

// File: tb/tb_add32_arbiter.sv
// Directed self-checking bench for add32_arbiter (NREQ = 4).
module tb_add32_arbiter;

  localparam int NREQ = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic [NREQ-1:0]   req_sign;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [31:0]       rsp_result;
  logic              rsp_overflow;

  int checks = 0;
  int errors = 0;

  add32_arbiter #(
    .NREQ(NREQ)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_sub     (req_sub),
    .req_sign    (req_sign),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_overflow(rsp_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Directed vectors: requester, a, b, sub, sign, wrapped result, saturated result, overflow.
  int          v_id  [8] = '{0, 2, 3, 1, 0, 1, 2, 3};
  logic [31:0] v_a   [8] = '{32'h5, 32'h7FFF_FFFF, 32'h2, 32'h8000_0000,
                             32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hA, 32'h7FFF_FFFF};
  logic [31:0] v_b   [8] = '{32'h3, 32'h1, 32'h5, 32'h1,
                             32'h2, 32'h1, 32'h3, 32'hFFFF_FFFF};
  logic        v_sub [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        v_sgn [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] v_wrap[8] = '{32'h8, 32'h8000_0000, 32'hFFFF_FFFD, 32'h7FFF_FFFF,
                             32'h1, 32'hFFFF_FFFE, 32'h7, 32'h8000_0000};
  logic [31:0] v_sat [8] = '{32'h8, 32'h7FFF_FFFF, 32'h0, 32'h8000_0000,
                             32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h7, 32'h7FFF_FFFF};
  logic        v_ovf [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic sgn);
    req_valid          = '0;
    req_valid[id]      = 1'b1;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_sub[id]        = sub;
    req_sign[id]       = sgn;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    req_sign  = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid);
    end
    checks++;
    if (rsp_id !== 2'd0) begin
      errors++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id);
    end
    checks++;
    if (rsp_result !== 32'h0) begin
      errors++; $display("FAIL reset_rsp_result got %h want 0", rsp_result);
    end
    checks++;
    if (rsp_overflow !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_overflow got %b want 0", rsp_overflow);
    end
    rst = 1'b0;
  endtask

  task automatic test_ops;
    logic [31:0] exp_res;
    logic [3:0]  exp_rdy;
    for (int i = 0; i < 8; i++) begin
`ifdef ADD32_ARB_SAT_EN
      exp_res = v_sat[i];
`else
      exp_res = v_wrap[i];
`endif
      exp_rdy = 4'b0001 << v_id[i];
      @(negedge clk);
      set_req(v_id[i], v_a[i], v_b[i], v_sub[i], v_sgn[i]);
      #1;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL op%0d_grant got %b want %b", i, req_ready, exp_rdy);
      end
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL op%0d_calc valid %b ready %b want 0 0000", i, rsp_valid, req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1) begin
        errors++; $display("FAIL op%0d_rsp_valid got %b want 1", i, rsp_valid);
      end
      checks++;
      if (rsp_id !== 2'(v_id[i])) begin
        errors++; $display("FAIL op%0d_rsp_id got %0d want %0d", i, rsp_id, v_id[i]);
      end
      checks++;
      if (rsp_result !== exp_res) begin
        errors++; $display("FAIL op%0d_result got %h want %h", i, rsp_result, exp_res);
      end
      checks++;
      if (rsp_overflow !== v_ovf[i]) begin
        errors++; $display("FAIL op%0d_overflow got %b want %b", i, rsp_overflow, v_ovf[i]);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    set_req(1, 32'd10, 32'd20, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    // Other requesters wait while the response is stalled.
    set_req(0, 32'd1, 32'd1, 1'b0, 1'b0);
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 32'd30 ||
          rsp_overflow !== 1'b0 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold_c%0d valid %b id %0d res %h ovf %b ready %b want 1 1 1e 0 0000",
                 c, rsp_valid, rsp_id, rsp_result, rsp_overflow, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_released got %b want 0", rsp_valid);
    end
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL bp_next_grant got %b want 0100", req_ready);
    end
    req_valid = '0;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL bp_withdraw got %b want 0000", req_ready);
    end
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    set_req(0, 32'd1, 32'd1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || rsp_id !== 2'd0 ||
        rsp_result !== 32'h0 || rsp_overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs valid %b ready %b id %0d res %h ovf %b want all 0",
               rsp_valid, req_ready, rsp_id, rsp_result, rsp_overflow);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_no_rsp got %b want 0", rsp_valid);
    end
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = 32'(i * 100);
      req_b[32*i +: 32] = 32'd1;
    end
    req_sub   = '0;
    req_sign  = '0;
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL rst_mid_ptr got %b want 0001", req_ready);
    end
  endtask

  task automatic test_fairness;
    int grants[$];
    int rsps[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int per_id[4]    = '{0, 0, 0, 0};
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) grants.push_back(i);
      end
      if (rsp_valid) begin
        rsps.push_back(int'(rsp_id));
        checks++;
        if (rsp_result !== 32'(int'(rsp_id) * 100 + 1)) begin
          errors++;
          $display("FAIL fair_result id %0d got %h want %h", rsp_id, rsp_result,
                   32'(int'(rsp_id) * 100 + 1));
        end
      end
      if (grants.size() >= 5 && rsps.size() >= 4) break;
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    req_valid = '0;
    checks++;
    if (grants.size() < 5 || rsps.size() < 4) begin
      errors++;
      $display("FAIL fair_timeout grants %0d rsps %0d want 5 4", grants.size(), rsps.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (grants[k] !== exp_order[k]) begin
          errors++; $display("FAIL fair_grant%0d got %0d want %0d", k, grants[k], exp_order[k]);
        end
      end
      for (int k = 0; k < 4; k++) per_id[rsps[k]]++;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (per_id[k] !== 1) begin
          errors++; $display("FAIL fair_rsp_count id %0d got %0d want 1", k, per_id[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_backpressure();
    test_reset_mid_op();
    test_fairness();
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
